// File: rtl/mul_float_pipe_if.sv
// Streaming handshake bundle for mul_float_pipe: operand pair in, product and flags out.
interface mul_float_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/mul_float_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, multiply, normalise/round/pack.
// Round-to-nearest-even, no subnormal inputs or outputs, flags {invalid, overflow, underflow, inexact}.
module mul_float_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_float_pipe_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_INF,
    CLS_INV,
    CLS_NAN
  } cls_t;

  logic               w_advance;
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_fa, w_fb;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  cls_t               w_cls;
  logic [EW-1:0]      w_e1;

  logic               r1_valid;
  logic               r1_sign;
  logic [EW-1:0]      r1_e;
  logic [MAN_W:0]     r1_ma, r1_mb;
  cls_t               r1_cls;

  logic               r2_valid;
  logic               r2_sign;
  logic [EW-1:0]      r2_e;
  logic [PW-1:0]      r2_p;
  cls_t               r2_cls;

  logic               r3_valid;
  logic [W-1:0]       r3_result;
  logic [3:0]         r3_flags;

  logic               w_n;
  logic [PW-2:0]      w_pn;
  logic [MAN_W-1:0]   w_mant;
  logic               w_guard, w_sticky, w_inc;
  logic [MAN_W:0]     w_mrnd;
  logic [EW-1:0]      w_e3;
  logic               w_ovf, w_unf;
  logic [W-1:0]       w_res;
  logic [3:0]         w_flags;

  assign w_advance    = ~r3_valid | io.out_ready;
  assign io.in_ready  = w_advance;
  assign io.out_valid = r3_valid;
  assign io.result    = r3_result;
  assign io.flags     = r3_flags;

  // Stage 1: unpack and classify
  assign w_sa = io.a[W-1];
  assign w_sb = io.b[W-1];
  assign w_ea = io.a[W-2 -: EXP_W];
  assign w_eb = io.b[W-2 -: EXP_W];
  assign w_fa = io.a[MAN_W-1:0];
  assign w_fb = io.b[MAN_W-1:0];

  // Exponent 0 covers subnormals too: they are taken as signed zero.
  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_a_inf  = (&w_ea) & ~|w_fa;
  assign w_b_inf  = (&w_eb) & ~|w_fb;
  assign w_a_nan  = (&w_ea) & |w_fa;
  assign w_b_nan  = (&w_eb) & |w_fb;

  always_comb begin
    w_cls = CLS_NUM;
    if (w_a_nan | w_b_nan)
      w_cls = CLS_NAN;
    else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
      w_cls = CLS_INV;
    else if (w_a_inf | w_b_inf)
      w_cls = CLS_INF;
    else if (w_a_zero | w_b_zero)
      w_cls = CLS_ZERO;
  end

  // Two's-complement exponent sum; the top bit acts as the sign.
  assign w_e1 = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_X;

  // Stage 3: normalise, round to nearest even, pack
  assign w_n      = r2_p[PW-1];
  assign w_pn     = w_n ? r2_p[PW-2:0] : {r2_p[PW-3:0], 1'b0};
  assign w_mant   = w_pn[PW-2 -: MAN_W];
  assign w_guard  = w_pn[MAN_W];
  assign w_sticky = |w_pn[MAN_W-1:0];
  assign w_inc    = w_guard & (w_sticky | w_mant[0]);
  assign w_mrnd   = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_inc};
  assign w_e3     = r2_e + {{(EW-1){1'b0}}, w_n} + {{(EW-1){1'b0}}, w_mrnd[MAN_W]};
  assign w_ovf    = ~w_e3[EW-1] & (w_e3[EW-2:0] >= {1'b0, {EXP_W{1'b1}}});
  assign w_unf    = w_e3[EW-1] | (w_e3 == '0);

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    unique case (r2_cls)
      CLS_NAN: w_res = QNAN;
      CLS_INV: begin
        w_res   = QNAN;
        w_flags = 4'b1000;
      end
      CLS_INF:  w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: w_res = {r2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_ovf) begin
          w_res   = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flags = 4'b0101;
        end else if (w_unf) begin
          w_res   = {r2_sign, {(W-1){1'b0}}};
          w_flags = 4'b0011;
        end else begin
          w_res   = {r2_sign, w_e3[EXP_W-1:0], w_mrnd[MAN_W-1:0]};
          w_flags = {3'b000, w_guard | w_sticky};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_flags  <= '0;
    end else if (w_advance) begin
      r1_valid <= io.in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_result <= w_res;
        r3_flags  <= w_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r1_sign <= w_sa ^ w_sb;
      r1_e    <= w_e1;
      r1_ma   <= {1'b1, w_fa};
      r1_mb   <= {1'b1, w_fb};
      r1_cls  <= w_cls;
      r2_sign <= r1_sign;
      r2_e    <= r1_e;
      r2_p    <= PW'(r1_ma) * PW'(r1_mb);
      r2_cls  <= r1_cls;
    end
  end
endmodule

// File: tb/tb_mul_float_pipe.sv
// Bench for mul_float_pipe: single (8/23) and half (5/10) instances checked against
// an arithmetic reference model, with directed latency, backpressure and reset scenarios.
module tb_mul_float_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_acc_sp = 0, n_acc_hp = 0;
  int   n_out_sp = 0, n_out_hp = 0;
  logic [63:0] q_sp[$];
  logic [63:0] q_hp[$];

  always #5 clk = ~clk;

  mul_float_pipe_if #(.EXP_W(8), .MAN_W(23)) sp_if ();
  mul_float_pipe_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

  mul_float_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst_n(rst_n), .io(sp_if));
  mul_float_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst_n(rst_n), .io(hp_if));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns {flags, result} with flags just above the W-bit result.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input int E, input int M);
    logic [63:0] one, emax, fmask, ea, eb, fa, fb, res, prod, keep, rem, half, sgn;
    logic [3:0]  fl;
    int          bias, ex, msb, shift;
    logic        nan, inv, inf, zero;
    one   = 64'd1;
    emax  = (one << E) - 1;
    fmask = (one << M) - 1;
    bias  = (1 << (E - 1)) - 1;
    ea    = (a >> M) & emax;
    eb    = (b >> M) & emax;
    fa    = a & fmask;
    fb    = b & fmask;
    sgn   = (a[E+M] ^ b[E+M]) ? (one << (E + M)) : 64'd0;
    nan   = (ea == emax && fa != 0) || (eb == emax && fb != 0);
    inf   = (ea == emax) || (eb == emax);
    zero  = (ea == 0) || (eb == 0);
    inv   = !nan && inf && zero;
    fl    = 4'b0000;
    if (nan || inv) begin
      res = (emax << M) | (one << (M - 1));
      if (inv) fl = 4'b1000;
    end else if (inf) begin
      res = sgn | (emax << M);
    end else if (zero) begin
      res = sgn;
    end else begin
      prod = ((one << M) | fa) * ((one << M) | fb);
      msb  = 0;
      for (int k = 63; k >= 0; k--) if (prod[k] && msb == 0) msb = k;
      shift = msb - M;
      keep  = prod >> shift;
      rem   = prod - (keep << shift);
      half  = one << (shift - 1);
      ex    = int'(ea) + int'(eb) - bias + (msb - 2 * M);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep == (one << (M + 1))) begin
        keep = keep >> 1;
        ex   = ex + 1;
      end
      if (ex >= int'(emax)) begin
        res = sgn | (emax << M);
        fl  = 4'b0101;
      end else if (ex <= 0) begin
        res = sgn;
        fl  = 4'b0011;
      end else begin
        res = sgn | (64'(ex) << M) | (keep - (one << M));
        fl  = {3'b000, rem != 0};
      end
    end
    return (64'(fl) << (E + M + 1)) | res;
  endfunction

  function automatic logic [63:0] rand_op(input int E, input int M);
    logic [63:0] one, emax, ex, man;
    int          bias, sel;
    one  = 64'd1;
    emax = (one << E) - 1;
    bias = (1 << (E - 1)) - 1;
    sel  = $urandom_range(0, 15);
    case (sel)
      0:       ex = 0;
      1:       ex = emax;
      2:       ex = 1;
      3:       ex = emax - 1;
      4, 5, 6: ex = 64'($urandom_range(bias - 2, bias + 2));
      default: ex = 64'($urandom_range(0, int'(emax)));
    endcase
    man = {$urandom, $urandom} & ((one << M) - 1);
    if ($urandom_range(0, 7) == 0) man = 0;
    return (64'($urandom_range(0, 1)) << (E + M)) | (ex << M) | man;
  endfunction

  function automatic logic [63:0] word(input int inst);
    return (inst == 0) ? {28'd0, sp_if.flags, sp_if.result} : {44'd0, hp_if.flags, hp_if.result};
  endfunction

  function automatic logic ovalid(input int inst);
    return (inst == 0) ? sp_if.out_valid : hp_if.out_valid;
  endfunction

  task automatic set_in(input int inst, input logic vld, input logic [63:0] a, input logic [63:0] b);
    if (inst == 0) begin
      sp_if.in_valid = vld; sp_if.a = a[31:0]; sp_if.b = b[31:0];
    end else begin
      hp_if.in_valid = vld; hp_if.a = a[15:0]; hp_if.b = b[15:0];
    end
  endtask

  // Presents one pair and returns 1 time unit after the edge that accepted it.
  task automatic issue(input int inst, input logic [63:0] a, input logic [63:0] b);
    logic acc;
    int   tries;
    set_in(inst, 1'b1, a, b);
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = (inst == 0) ? sp_if.in_ready : hp_if.in_ready;
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: got in_ready 0 for 50 cycles expected 1");
    end
    set_in(inst, 1'b0, a, b);
  endtask

  task automatic directed(input int inst, input string nm, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
    issue(inst, a, b);
    @(posedge clk); #1;
    check({nm, "_early"}, 64'(ovalid(inst)), 64'd0);
    @(posedge clk); #1;
    check({nm, "_valid"}, 64'(ovalid(inst)), 64'd1);
    check({nm, "_word"}, word(inst), exp);
    @(posedge clk); #1;
  endtask

  // Compare process: scoreboard fed by input transfers, checked on every valid output cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_sp.delete();
      q_hp.delete();
      check("rst_sp", {sp_if.out_valid, sp_if.flags, sp_if.result}, 64'd0);
      check("rst_hp", {hp_if.out_valid, hp_if.flags, hp_if.result}, 64'd0);
    end else begin
      if (sp_if.out_valid) begin
        if (q_sp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL spurious_sp: got result %h expected no pending result", word(0));
        end else begin
          check("stream_sp", word(0), q_sp[0]);
          if (sp_if.out_ready) begin void'(q_sp.pop_front()); n_out_sp++; end
        end
      end
      if (hp_if.out_valid) begin
        if (q_hp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL spurious_hp: got result %h expected no pending result", word(1));
        end else begin
          check("stream_hp", word(1), q_hp[0]);
          if (hp_if.out_ready) begin void'(q_hp.pop_front()); n_out_hp++; end
        end
      end
      if (sp_if.in_valid && sp_if.in_ready) begin
        q_sp.push_back(model(64'(sp_if.a), 64'(sp_if.b), 8, 23));
        n_acc_sp++;
      end
      if (hp_if.in_valid && hp_if.in_ready) begin
        q_hp.push_back(model(64'(hp_if.a), 64'(hp_if.b), 5, 10));
        n_acc_hp++;
      end
    end
  end

  typedef struct {
    int          inst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
  } vec_t;

  vec_t dv[10] = '{
    '{0, 64'h3FC00000, 64'h40000000, 64'h0_40400000},
    '{0, 64'h3F800001, 64'h3F800001, 64'h1_3F800002},
    '{0, 64'h7F000000, 64'h40000000, 64'h5_7F800000},
    '{0, 64'h00800000, 64'h3F000000, 64'h3_00000000},
    '{0, 64'h7F800000, 64'h00000000, 64'h8_7FC00000},
    '{0, 64'hFF800000, 64'h40000000, 64'h0_FF800000},
    '{0, 64'h7F800001, 64'h3F800000, 64'h0_7FC00000},
    '{0, 64'h00000001, 64'hC0000000, 64'h0_80000000},
    '{1, 64'h3C00,     64'h4000,     64'h0_4000},
    '{1, 64'h7BFF,     64'h4000,     64'h5_7C00}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    logic [63:0] held;
    int          base_out, base_sp, base_hp, k;
    rst_n = 1'b0;
    set_in(0, 1'b0, 64'd0, 64'd0);
    set_in(1, 1'b0, 64'd0, 64'd0);
    sp_if.out_ready = 1'b1;
    hp_if.out_ready = 1'b1;
    #1;
    check("rst_in_ready", {sp_if.in_ready, hp_if.in_ready}, 64'd3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dv[i])
      check($sformatf("pin%0d", i), model(dv[i].a, dv[i].b, dv[i].inst == 0 ? 8 : 5,
                                          dv[i].inst == 0 ? 23 : 10), dv[i].w);
    foreach (dv[i])
      directed(dv[i].inst, $sformatf("dir%0d", i), dv[i].a, dv[i].b, dv[i].w);

    // Backpressure: six back-to-back ops, output held off for five cycles.
    base_out = n_out_sp;
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(0, 64'h3F800000 + 64'(i) * 64'h00123457, 64'h40490FDB);
      end
      begin
        k = 0;
        while (!sp_if.out_valid && k < 20) begin @(posedge clk); #1; k++; end
        check("bp_first", 64'(sp_if.out_valid), 64'd1);
        sp_if.out_ready = 1'b0;
        held = word(0);
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 64'(sp_if.in_ready), 64'd0);
          check("bp_hold", {63'd0, sp_if.out_valid} << 40 | word(0), 64'd1 << 40 | held);
        end
        @(posedge clk); #1;
        sp_if.out_ready = 1'b1;
      end
    join
    repeat (8) begin @(posedge clk); #1; end
    check("bp_count", 64'(n_out_sp - base_out), 64'd6);
    check("bp_drained", 64'(q_sp.size()), 64'd0);

    // Reset with operations in flight.
    issue(0, 64'h40400000, 64'h40400000);
    issue(0, 64'h40A00000, 64'h3F000000);
    @(posedge clk); #1;
    check("rst_pre_ov", 64'(sp_if.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_async", {sp_if.out_valid, sp_if.flags, sp_if.result}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 64'(sp_if.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    directed(0, "rst_after", 64'h40400000, 64'h40400000, 64'h0_41100000);

    // Random streaming on both widths with random stalls.
    base_sp = n_acc_sp;
    base_hp = n_acc_hp;
    for (int cyc = 0; cyc < 40000 && ((n_acc_sp - base_sp) < 4000 || (n_acc_hp - base_hp) < 10000); cyc++) begin
      set_in(0, $urandom_range(0, 3) != 0, rand_op(8, 23), rand_op(8, 23));
      set_in(1, $urandom_range(0, 3) != 0, rand_op(5, 10), rand_op(5, 10));
      sp_if.out_ready = $urandom_range(0, 3) != 0;
      hp_if.out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 64'd0, 64'd0);
    set_in(1, 1'b0, 64'd0, 64'd0);
    sp_if.out_ready = 1'b1;
    hp_if.out_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("rand_cnt_sp", 64'((n_acc_sp - base_sp) >= 4000), 64'd1);
    check("rand_cnt_hp", 64'((n_acc_hp - base_hp) >= 10000), 64'd1);
    check("rand_drain", 64'(q_sp.size() + q_hp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
